// File: rtl/blit_pkg.sv
// Shared types, widths and default parameters for the layer blitter.
package blit_pkg;

  localparam int unsigned PIX_W   = 8;
  localparam int unsigned COORD_W = 10;
  localparam int unsigned SUM_W   = COORD_W + 1;
  localparam int unsigned LAYER_W = 33;

  localparam int unsigned        DEF_NUM_LAYERS  = 14;
  localparam int unsigned        DEF_FB_W        = 160;
  localparam int unsigned        DEF_FB_H        = 120;
  localparam logic [PIX_W-1:0]   DEF_TRANSPARENT = 8'h00;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    COPY,
    DRAIN,
    DONE
  } state_e;

  // Destination coordinate base + (pos - origin), widened by one bit so off-screen sums stay visible.
  function automatic logic [SUM_W-1:0] dest_coord(input logic [COORD_W-1:0] base,
                                                  input logic [COORD_W-1:0] pos,
                                                  input logic [COORD_W-1:0] origin);
    return SUM_W'(base) + (SUM_W'(pos) - SUM_W'(origin));
  endfunction

endpackage

// File: rtl/blit_addr_gen.sv
// Row-major raster counter over an inclusive source rectangle.
module blit_addr_gen
  import blit_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [COORD_W-1:0] ini_x_i,
  input  logic [COORD_W-1:0] ini_y_i,
  input  logic [COORD_W-1:0] fin_x_i,
  input  logic [COORD_W-1:0] fin_y_i,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic               last_o
);

  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [COORD_W-1:0] ini_x_q, fin_x_q, fin_y_q;

  // Next position: load the origin, or advance x and wrap into the next row.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (load_i) begin
      x_d = ini_x_i;
      y_d = ini_y_i;
    end else if (step_i) begin
      if (x_q == fin_x_q) begin
        x_d = ini_x_q;
        y_d = y_q + COORD_W'(1);
      end else begin
        x_d = x_q + COORD_W'(1);
      end
    end
  end

  // Position and rectangle bounds registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q     <= '0;
      y_q     <= '0;
      ini_x_q <= '0;
      fin_x_q <= '0;
      fin_y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      if (load_i) begin
        ini_x_q <= ini_x_i;
        fin_x_q <= fin_x_i;
        fin_y_q <= fin_y_i;
      end
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign last_o = (x_q == fin_x_q) && (y_q == fin_y_q);

endmodule

// File: rtl/layer_blitter.sv
// Layer blitter: walks every layer descriptor and copies its VRAM rectangle into the framebuffer,
// skipping transparent and off-screen pixels.
module layer_blitter
  import blit_pkg::*;
#(
  parameter int unsigned      NUM_LAYERS  = DEF_NUM_LAYERS,
  parameter int unsigned      FB_W        = DEF_FB_W,
  parameter int unsigned      FB_H        = DEF_FB_H,
  parameter logic [PIX_W-1:0] TRANSPARENT = DEF_TRANSPARENT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [LAYER_W-1:0] layer,
  input  logic [COORD_W-1:0] vram_inicio_X,
  input  logic [COORD_W-1:0] vram_inicio_Y,
  input  logic [COORD_W-1:0] vram_final_X,
  input  logic [COORD_W-1:0] vram_final_Y,
  input  logic [COORD_W-1:0] FB_X,
  input  logic [COORD_W-1:0] FB_Y,
  output logic               vram_rd_en,
  output logic [COORD_W-1:0] vram_rd_x,
  output logic [COORD_W-1:0] vram_rd_y,
  input  logic [PIX_W-1:0]   vram_rd_data,
  output logic               fb_wr_en,
  output logic [COORD_W-1:0] fb_wr_x,
  output logic [COORD_W-1:0] fb_wr_y,
  output logic [PIX_W-1:0]   fb_wr_data
);

  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);

  state_e             state_q, state_d;
  logic [LAYER_W-1:0] layer_q, layer_d;
  logic               busy_q, busy_d, done_q, done_d, rd_en_q, rd_en_d;
  logic [COORD_W-1:0] fb_x_q, fb_y_q, ini_x_q, ini_y_q;
  logic               wr_valid_q;
  logic [SUM_W-1:0]   wr_x_q, wr_y_q;
  logic               desc_empty, last_layer, addr_load, addr_step, addr_last;
  logic [COORD_W-1:0] addr_x, addr_y;

  assign desc_empty = (vram_final_X < vram_inicio_X) || (vram_final_Y < vram_inicio_Y);
  assign last_layer = (layer_q == LAST_LAYER);
  assign addr_load  = (state_q == FETCH) && !desc_empty;
  assign addr_step  = (state_q == COPY) && !addr_last;

  blit_addr_gen u_addr (
    .clk     (clk),
    .reset   (reset),
    .load_i  (addr_load),
    .step_i  (addr_step),
    .ini_x_i (vram_inicio_X),
    .ini_y_i (vram_inicio_Y),
    .fin_x_i (vram_final_X),
    .fin_y_i (vram_final_Y),
    .x_o     (addr_x),
    .y_o     (addr_y),
    .last_o  (addr_last)
  );

  // Frame sequencing and the registered status/read-enable outputs that follow it.
  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    rd_en_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          layer_d = '0;
        end
      end
      FETCH: begin
        if (!desc_empty) begin
          state_d = COPY;
        end else if (last_layer) begin
          state_d = DONE;
        end else begin
          layer_d = layer_q + LAYER_W'(1);
        end
      end
      COPY: begin
        if (addr_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (last_layer) begin
          state_d = DONE;
        end else begin
          state_d = FETCH;
          layer_d = layer_q + LAYER_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    rd_en_d = (state_d == COPY);
  end

  // FSM state and registered control outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      layer_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_en_q <= rd_en_d;
    end
  end

  // Destination origin and source origin captured at the end of FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      fb_x_q  <= '0;
      fb_y_q  <= '0;
      ini_x_q <= '0;
      ini_y_q <= '0;
    end else if (state_q == FETCH) begin
      fb_x_q  <= FB_X;
      fb_y_q  <= FB_Y;
      ini_x_q <= vram_inicio_X;
      ini_y_q <= vram_inicio_Y;
    end
  end

  // Write stage: destination of each read, lined up with its returning data one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_valid_q <= 1'b0;
      wr_x_q     <= '0;
      wr_y_q     <= '0;
    end else begin
      wr_valid_q <= rd_en_q;
      wr_x_q     <= dest_coord(fb_x_q, addr_x, ini_x_q);
      wr_y_q     <= dest_coord(fb_y_q, addr_y, ini_y_q);
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign layer      = layer_q;
  assign vram_rd_en = rd_en_q;
  assign vram_rd_x  = addr_x;
  assign vram_rd_y  = addr_y;
  assign fb_wr_x    = wr_x_q[COORD_W-1:0];
  assign fb_wr_y    = wr_y_q[COORD_W-1:0];
  assign fb_wr_data = wr_valid_q ? vram_rd_data : '0;
  assign fb_wr_en   = wr_valid_q && (vram_rd_data != TRANSPARENT)
                      && (wr_x_q < SUM_W'(FB_W)) && (wr_y_q < SUM_W'(FB_H));

endmodule

// File: doc/layer_blitter.md
LAYER_BLITTER -- requirements
Module: layer_blitter

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 14, number of layers walked per frame (index 0..NUM_LAYERS-1).
REQ-002 SHALL have parameter FB_W, default 160, framebuffer width in pixels; writes at x>=FB_W are clipped.
REQ-003 SHALL have parameter FB_H, default 120, framebuffer height in pixels; writes at y>=FB_H are clipped.
REQ-004 SHALL have parameter TRANSPARENT, default 8'h00, pixel value never written.
REQ-005 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high.
REQ-007 SHALL have the following port groups:
- start  in  1  frame request pulse.
- busy  out  1  high from accepted start through DONE state.
- done  out  1  one-cycle pulse at frame completion.
- layer  out  33  layer index presented to the state renderer.
- vram_inicio_X, vram_inicio_Y, vram_final_X, vram_final_Y  in  10 each  inclusive source rectangle for current layer.
- FB_X, FB_Y  in  10 each  destination top-left for current layer.
- vram_rd_en  out  1; vram_rd_x, vram_rd_y  out  10  VRAM read request.
- vram_rd_data  in  8  read data, valid exactly one cycle after vram_rd_en.
- fb_wr_en  out  1; fb_wr_x, fb_wr_y  out  10; fb_wr_data  out  8  framebuffer write.

Function
REQ-008 SHALL implement FSM states IDLE, FETCH, COPY, DRAIN, DONE.
REQ-009 IDLE->FETCH on start=1; start SHALL be ignored in every other state, including the DONE cycle.
REQ-010 SHALL drive layer=0 on entry to FETCH from IDLE.
REQ-011 In FETCH, layer holds the current index; descriptor inputs are combinational from the renderer and SHALL be latched at the end of the FETCH cycle.
REQ-012 FETCH SHALL last exactly 1 cycle.
REQ-013 If final_X<inicio_X or final_Y<inicio_Y, the layer SHALL be skipped with no reads, going directly to the next FETCH or DONE.
REQ-014 COPY SHALL issue one read per cycle in row-major order.
- x runs inicio_X..final_X, then wraps to inicio_X and increments y, until (final_X, final_Y).
- W*H read cycles, W=final_X-inicio_X+1, H=final_Y-inicio_Y+1.
REQ-015 The write stage SHALL occur one cycle after each read, with fb_wr_x=FB_X+(rd_x-inicio_X) and fb_wr_y=FB_Y+(rd_y-inicio_Y).
- Sums computed in 11 bits.
- fb_wr_data=vram_rd_data.
REQ-016 fb_wr_en SHALL be 1 only when data!=TRANSPARENT, 11-bit x<FB_W and 11-bit y<FB_H; clipped or transparent pixels still consume their cycle.
REQ-017 DRAIN SHALL last 1 cycle and complete the final write; it then increments layer and enters FETCH, or enters DONE after layer NUM_LAYERS-1.
REQ-018 Per valid layer SHALL take 1+W*H+1 cycles; per skipped layer, 1 cycle.
REQ-019 DONE SHALL assert done for 1 cycle, then go to IDLE; busy SHALL drop in the IDLE cycle.
REQ-020 vram_rd_en SHALL be 0 outside COPY; fb_wr_en SHALL be 0 outside COPY/DRAIN.
REQ-021 Layer index arithmetic SHALL be unsigned; layer never exceeds NUM_LAYERS-1.

Reset
REQ-022 On reset, SHALL enter IDLE and set outputs:
- busy=0, done=0, layer=0.
- vram_rd_en=0, fb_wr_en=0.
- rd/wr coordinates=0, fb_wr_data=0.
REQ-023 Reset mid-frame SHALL abort immediately: no write after the reset cycle and no done pulse; the pending pipeline write SHALL be discarded.

Structure
REQ-024 Package blit_pkg SHALL hold: the state enum, PIX_W=8, COORD_W=10, FB_W, FB_H, TRANSPARENT and NUM_LAYERS defaults.
REQ-025 Sub-module blit_addr_gen SHALL hold the x/y raster counter with load, step and last flag; FSM and write stage stay in layer_blitter.

Verification
REQ-026 NUM_LAYERS=1, rect (0,0)-(1,1), FB (10,20), data 5,6,7,8 -> writes (10,20)=5, (11,20)=6, (10,21)=7, (11,21)=8; done 7 cycles after start accepted.
REQ-027 Same rect with data 5,0,7,0 -> exactly two fb_wr_en pulses, at (10,20) and (10,21).
REQ-028 Rect (0,0)-(4,0), FB_X=158, FB_Y=5 -> only x=158,159 written; 5 read cycles.
REQ-029 NUM_LAYERS=2, layer0 final_X<inicio_X, layer1 1x1 -> zero reads for layer0; layer=1 on the cycle after layer0 FETCH.
REQ-030 Reset asserted mid-COPY -> next cycle busy=0, fb_wr_en=0, layer=0; start pulsed during busy ignored (no restart, one done).
REQ-031 Default 14 layers with renderer model (scenario 160x120) -> layer sequence 0..13, single done, pixel count matches model.
